data_m_copy_master: RTL and testbench

- Bus initiator for the data_m memory/IO bus; it drives the same handshake that the on-chip register peripherals answer.
- Copies COUNT 16-bit words from a source word address to a destination word address using alternating read and write transactions.
- Sits beside the CPU as a simple DMA engine; its bus port goes through the existing data bus arbiter.

---
 rtl/data_m_copy_master.sv | 179 +++++++++++++++++
 tb/tb_data_m_copy_master.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_m_copy_master.sv
// Word-copy DMA initiator on the data_m bus: reads one word, writes it, repeats COUNT times.
// Optional ack-timeout watchdog is built when CONFIG_DATA_M_COPY_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module data_m_copy_master #(
   parameter int ADDR_WIDTH     = 19,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [15:0]           count,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] data_m_addr,
   input  logic [15:0]           data_m_data_in,
   output logic [15:0]           data_m_data_out,
   output logic                  data_m_access,
   input  logic                  data_m_ack,
   output logic                  data_m_wr_en,
   output logic [1:0]            data_m_bytesel
);

   typedef enum logic [2:0] {IDLE, READ, READ_GAP, WRITE, WRITE_GAP} state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   src_reg, src_next;
   logic [ADDR_WIDTH-1:0]   dst_reg, dst_next;
   logic [15:0]             remaining_reg, remaining_next;
   logic [15:0]             hold_reg, hold_next;
   logic                    first_reg, first_next;
   logic                    done_pulse_reg, done_pulse_next;
   logic                    ack_valid;
   logic                    timeout_hit;

   generate
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   // An ack in the first cycle of a request cannot belong to it.
   assign ack_valid = data_m_ack & ~first_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         src_reg        <= '0;
         dst_reg        <= '0;
         remaining_reg  <= '0;
         hold_reg       <= '0;
         first_reg      <= 1'b0;
         done_pulse_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         src_reg        <= src_next;
         dst_reg        <= dst_next;
         remaining_reg  <= remaining_next;
         hold_reg       <= hold_next;
         first_reg      <= first_next;
         done_pulse_reg <= done_pulse_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      src_next        = src_reg;
      dst_next        = dst_reg;
      remaining_next  = remaining_reg;
      hold_next       = hold_reg;
      first_next      = 1'b0;
      done_pulse_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (count != 16'd0) begin
                  src_next       = src_addr;
                  dst_next       = dst_addr;
                  remaining_next = count;
                  first_next     = 1'b1;
                  state_next     = READ;
               end else begin
                  done_pulse_next = 1'b1;
               end
            end
         end
         READ: begin
            if (ack_valid) begin
               hold_next  = data_m_data_in;
               state_next = READ_GAP;
            end else if (timeout_hit) begin
               done_pulse_next = 1'b1;
               state_next      = IDLE;
            end
         end
         READ_GAP: begin
            first_next = 1'b1;
            state_next = WRITE;
         end
         WRITE: begin
            if (ack_valid) begin
               src_next       = src_reg + 1'b1;
               dst_next       = dst_reg + 1'b1;
               remaining_next = remaining_reg - 1'b1;
               state_next     = WRITE_GAP;
            end else if (timeout_hit) begin
               done_pulse_next = 1'b1;
               state_next      = IDLE;
            end
         end
         WRITE_GAP: begin
            if (remaining_reg == 16'd0) begin
               state_next = IDLE;
            end else begin
               first_next = 1'b1;
               state_next = READ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      data_m_access   = 1'b0;
      data_m_wr_en    = 1'b0;
      data_m_bytesel  = 2'b00;
      data_m_addr     = '0;
      data_m_data_out = 16'h0000;
      if (state_reg == READ) begin
         data_m_access  = 1'b1;
         data_m_bytesel = 2'b11;
         data_m_addr    = src_reg;
      end else if (state_reg == WRITE) begin
         data_m_access   = 1'b1;
         data_m_wr_en    = 1'b1;
         data_m_bytesel  = 2'b11;
         data_m_addr     = dst_reg;
         data_m_data_out = hold_reg;
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = done_pulse_reg | ((state_reg == WRITE_GAP) && (remaining_reg == 16'd0));

`ifdef CONFIG_DATA_M_COPY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer_reg;
   logic          error_reg;
   logic          in_txn;

   assign in_txn      = (state_reg == READ) || (state_reg == WRITE);
   // timer_reg holds the number of completed cycles of the current request.
   assign timeout_hit = in_txn && (timer_reg == TW'(TIMEOUT_CYCLES - 1));
   assign error       = error_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_reg <= '0;
         error_reg <= 1'b0;
      end else begin
         if (first_next)
            timer_reg <= '0;
         else if (in_txn)
            timer_reg <= timer_reg + 1'b1;
         if ((state_reg == IDLE) && start)
            error_reg <= 1'b0;
         else if (timeout_hit && !ack_valid)
            error_reg <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_data_m_copy_master.sv
// Self-checking bench for data_m_copy_master: random-latency responder, transaction log
// compared against an expected copy sequence built from the source memory image.
`timescale 1ns/1ps
module tb_data_m_copy_master;
   localparam int AW   = 19;
   localparam int TO   = 8;
   localparam int MASK = (1 << AW) - 1;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } txn_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [15:0]   count = 16'h0;
   logic          busy, done, error;
   logic [AW-1:0] data_m_addr;
   logic [15:0]   data_m_data_in = 16'h0;
   logic [15:0]   data_m_data_out;
   logic          data_m_access;
   logic          data_m_ack = 1'b0;
   logic          data_m_wr_en;
   logic [1:0]    data_m_bytesel;

   data_m_copy_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
      .busy(busy), .done(done), .error(error),
      .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
      .data_m_data_out(data_m_data_out), .data_m_access(data_m_access),
      .data_m_ack(data_m_ack), .data_m_wr_en(data_m_wr_en),
      .data_m_bytesel(data_m_bytesel)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] mem [int];
   txn_t        log_q [$];
   txn_t        exp_q [$];
   int          lat_min = 1, lat_max = 1;
   bit          resp_enable = 1'b1;
   bit          hold_writes = 1'b0;
   int          wait_cnt = 0;
   int          cur_lat = 1;
   int          access_cycles = 0;

   function automatic logic [15:0] mem_val(input int a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   // Reference: word i is read from src+i then written unchanged to dst+i, ascending.
   function automatic void build_exp(input int src, input int dst, input int cnt);
      exp_q.delete();
      for (int i = 0; i < cnt; i++) begin
         int a;
         int b;
         a = (src + i) & MASK;
         b = (dst + i) & MASK;
         exp_q.push_back({1'b0, AW'(a), mem_val(a)});
         exp_q.push_back({1'b1, AW'(b), mem_val(a)});
      end
   endfunction

   function automatic void fill_mem(input int src, input int cnt);
      for (int i = 0; i < cnt; i++) mem[(src + i) & MASK] = 16'($urandom);
   endfunction

   // Responder: acks cur_lat cycles after access rises, logs each acknowledged transfer.
   always @(posedge clk) begin
      if (reset || !data_m_access || data_m_ack) begin
         if (!reset && data_m_access && data_m_ack)
            log_q.push_back({data_m_wr_en, data_m_addr,
                             data_m_wr_en ? data_m_data_out : data_m_data_in});
         data_m_ack     <= 1'b0;
         wait_cnt       <= 0;
         data_m_data_in <= 16'($urandom);
         cur_lat        <= $urandom_range(lat_max, lat_min);
      end else if (resp_enable && !(hold_writes && data_m_wr_en) && (wait_cnt + 1 >= cur_lat)) begin
         data_m_ack     <= 1'b1;
         data_m_data_in <= mem_val(int'(data_m_addr));
      end else begin
         wait_cnt       <= wait_cnt + 1;
         data_m_data_in <= 16'($urandom);
      end
   end

   // Bus protocol monitor.
   logic                 prev_access = 1'b0;
   logic                 prev_acked = 1'b0;
   logic [AW+16:0]       prev_bus = '0;
   always @(negedge clk) begin
      if (data_m_access) access_cycles++;
      if (!reset) begin
         if (prev_acked) begin
            checks++;
            if (data_m_access !== 1'b0) begin
               errors++;
               $display("FAIL ack_gap: access=%b after ack, required 0", data_m_access);
            end
         end
         if (prev_access && data_m_access && !prev_acked) begin
            checks++;
            if ({data_m_addr, data_m_wr_en, data_m_data_out} !== prev_bus) begin
               errors++;
               $display("FAIL bus_stable: addr/wr/data=%h, required %h",
                        {data_m_addr, data_m_wr_en, data_m_data_out}, prev_bus);
            end
         end
         checks++;
         if (data_m_access ? (data_m_bytesel !== 2'b11)
                           : ({data_m_bytesel, data_m_wr_en, data_m_data_out} !== 19'd0)) begin
            errors++;
            $display("FAIL bus_idle_values: access=%b bytesel=%b wr_en=%b data_out=%h",
                     data_m_access, data_m_bytesel, data_m_wr_en, data_m_data_out);
         end
      end
      prev_acked  = data_m_access && data_m_ack;
      prev_access = data_m_access;
      prev_bus    = {data_m_addr, data_m_wr_en, data_m_data_out};
   end

   // Stimulus helper: start held for 'hold' cycles (inputs scrambled after the first), then wait for done.
   task automatic run_copy(input int src, input int dst, input int cnt, input int hold,
                           output int done_at, output int pulses, output int busy_cycles);
      log_q.delete();
      access_cycles = 0;
      @(negedge clk);
      start    = 1'b1;
      src_addr = AW'(src);
      dst_addr = AW'(dst);
      count    = 16'(cnt);
      done_at  = -1;
      pulses   = 0;
      busy_cycles = 0;
      for (int k = 1; k <= 3000; k++) begin
         @(negedge clk);
         if (k < hold) begin
            src_addr = AW'($urandom);
            dst_addr = AW'($urandom);
            count    = 16'($urandom_range(100, 1));
         end else begin
            start = 1'b0;
         end
         if (busy) busy_cycles++;
         if (done) begin
            pulses++;
            if (done_at < 0) done_at = k;
         end
         if (done_at >= 0 && !busy && k >= done_at + 3) break;
      end
      start = 1'b0;
      checks++;
      if (done_at < 0) begin
         errors++;
         $display("FAIL copy_budget: done never seen, required a done pulse within 3000 cycles");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks += 5;
      if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
      if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", error); end
      if (data_m_access !== 1'b0) begin errors++; $display("FAIL reset_access: got %b, required 0", data_m_access); end
      if ({data_m_addr, data_m_wr_en, data_m_bytesel, data_m_data_out} !== '0) begin
         errors++;
         $display("FAIL reset_bus: got %h, required 0",
                  {data_m_addr, data_m_wr_en, data_m_bytesel, data_m_data_out});
      end
      reset = 1'b0;
      @(negedge clk);
      $display("test_reset: done");
   endtask

   task automatic compare_log(input string name);
      checks++;
      if (log_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL %s_txn_count: got %0d, required %0d", name, log_q.size(), exp_q.size());
      end
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_txn%0d: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                     name, i, log_q[i].wr, log_q[i].addr, log_q[i].data,
                     exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   task automatic test_single();
      int done_at, pulses, busy_cycles;
      lat_min = 1; lat_max = 1;
      mem[32'h100] = 16'hBEEF;
      build_exp(32'h100, 32'h200, 1);
      run_copy(32'h100, 32'h200, 1, 1, done_at, pulses, busy_cycles);
      compare_log("single");
      checks += 3;
      if (done_at !== 6)     begin errors++; $display("FAIL single_done_cycle: got %0d, required 6", done_at); end
      if (busy_cycles !== 6) begin errors++; $display("FAIL single_busy_cycles: got %0d, required 6", busy_cycles); end
      if (pulses !== 1)      begin errors++; $display("FAIL single_done_pulses: got %0d, required 1", pulses); end
      $display("test_single: read 0x00100 -> write 0x00200, done at cycle %0d", done_at);
   endtask

   task automatic test_multi_wrap();
      int done_at, pulses, busy_cycles, dst;
      lat_min = 1; lat_max = 7;
      dst = $urandom_range(32'h20000, 32'h10000);
      fill_mem(32'h7FFFE, 4);
      build_exp(32'h7FFFE, dst, 4);
      run_copy(32'h7FFFE, dst, 4, 1, done_at, pulses, busy_cycles);
      compare_log("multi");
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL multi_done_pulses: got %0d, required 1", pulses); end
      $display("test_multi_wrap: 4 words from 0x7fffe to 0x%05h, done at cycle %0d", dst, done_at);
   endtask

   task automatic test_zero_count();
      int done_at, pulses, busy_cycles;
      build_exp(32'h300, 32'h400, 0);
      run_copy(32'h300, 32'h400, 0, 1, done_at, pulses, busy_cycles);
      compare_log("zero");
      checks += 4;
      if (done_at !== 1)       begin errors++; $display("FAIL zero_done_cycle: got %0d, required 1", done_at); end
      if (busy_cycles !== 0)   begin errors++; $display("FAIL zero_busy: got %0d busy cycles, required 0", busy_cycles); end
      if (access_cycles !== 0) begin errors++; $display("FAIL zero_access: got %0d access cycles, required 0", access_cycles); end
      if (pulses !== 1)        begin errors++; $display("FAIL zero_done_pulses: got %0d, required 1", pulses); end
      $display("test_zero_count: done at cycle %0d", done_at);
   endtask

   task automatic test_start_held();
      int done_at, pulses, busy_cycles, src, dst;
      lat_min = 1; lat_max = 3;
      src = $urandom_range(32'h0FFFF, 32'h01000);
      dst = $urandom_range(32'h5FFFF, 32'h40000);
      fill_mem(src, 3);
      build_exp(src, dst, 3);
      run_copy(src, dst, 3, 8, done_at, pulses, busy_cycles);
      compare_log("held");
      checks += 2;
      if (pulses !== 1)  begin errors++; $display("FAIL held_done_pulses: got %0d, required 1", pulses); end
      if (busy !== 1'b0) begin errors++; $display("FAIL held_restart: busy=%b after done, required 0", busy); end
      $display("test_start_held: 3 words 0x%05h -> 0x%05h, done at cycle %0d", src, dst, done_at);
   endtask

   task automatic test_ack_at_limit();
      int done_at, pulses, busy_cycles;
      lat_min = TO - 1; lat_max = TO - 1;
      fill_mem(32'h500, 2);
      build_exp(32'h500, 32'h600, 2);
      run_copy(32'h500, 32'h600, 2, 1, done_at, pulses, busy_cycles);
      compare_log("limit");
      checks += 2;
      if (error !== 1'b0) begin errors++; $display("FAIL limit_error: got %b, required 0", error); end
      if (pulses !== 1)   begin errors++; $display("FAIL limit_done_pulses: got %0d, required 1", pulses); end
      $display("test_ack_at_limit: ack in cycle %0d of each request, done at cycle %0d", TO, done_at);
   endtask

   task automatic test_reset_mid();
      int  done_at, pulses, busy_cycles;
      bit  found;
      lat_min = 1; lat_max = 2;
      hold_writes = 1'b1;
      fill_mem(32'h700, 2);
      @(negedge clk);
      start = 1'b1; src_addr = AW'(32'h700); dst_addr = AW'(32'h800); count = 16'd2;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (data_m_access && data_m_wr_en) begin found = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midreset_reach_write: write request not seen within 100 cycles"); end
      reset = 1'b1;
      @(negedge clk);
      checks += 3;
      if (data_m_access !== 1'b0) begin errors++; $display("FAIL midreset_access: got %b, required 0", data_m_access); end
      if (busy !== 1'b0)          begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
      if (done !== 1'b0)          begin errors++; $display("FAIL midreset_done: got %b, required 0", done); end
      reset = 1'b0;
      hold_writes = 1'b0;
      fill_mem(32'h900, 1);
      build_exp(32'h900, 32'hA00, 1);
      run_copy(32'h900, 32'hA00, 1, 1, done_at, pulses, busy_cycles);
      compare_log("after_reset");
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL after_reset_done_pulses: got %0d, required 1", pulses); end
      $display("test_reset_mid: abort then 1-word copy, done at cycle %0d", done_at);
   endtask

`ifdef CONFIG_DATA_M_COPY_TIMEOUT_EN
   task automatic test_timeout();
      int done_at, pulses, busy_cycles;
      resp_enable = 1'b0;
      build_exp(32'hB00, 32'hC00, 0);
      run_copy(32'hB00, 32'hC00, 2, 1, done_at, pulses, busy_cycles);
      compare_log("timeout");
      checks += 4;
      if (access_cycles !== TO) begin errors++; $display("FAIL timeout_access_cycles: got %0d, required %0d", access_cycles, TO); end
      if (done_at !== TO + 1)   begin errors++; $display("FAIL timeout_done_cycle: got %0d, required %0d", done_at, TO + 1); end
      if (pulses !== 1)         begin errors++; $display("FAIL timeout_done_pulses: got %0d, required 1", pulses); end
      if (error !== 1'b1)       begin errors++; $display("FAIL timeout_error_set: got %b, required 1", error); end
      resp_enable = 1'b1;
      lat_min = 1; lat_max = 3;
      fill_mem(32'hD00, 1);
      build_exp(32'hD00, 32'hE00, 1);
      run_copy(32'hD00, 32'hE00, 1, 1, done_at, pulses, busy_cycles);
      compare_log("post_timeout");
      checks++;
      if (error !== 1'b0) begin errors++; $display("FAIL timeout_error_clear: got %b, required 0", error); end
      $display("test_timeout: request dropped after %0d cycles, error cleared by next start", TO);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_multi_wrap();
      test_zero_count();
      test_start_held();
      test_ack_at_limit();
      test_reset_mid();
`ifdef CONFIG_DATA_M_COPY_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
